// File: rtl/cache_types.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cache_types : shared state encoding and line types for data_cache   (rev 1.0)
// -----------------------------------------------------------------------------
package cache_types;

   localparam int LINE_BITS  = 256;
   localparam int LINE_BYTES = 32;
   localparam int OFFSET_W   = 5;
   localparam int WORD_W     = 3;

   typedef logic [LINE_BITS-1:0] cache_line_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FILL      = 2'd2
   } cache_state_t;

endpackage
`default_nettype wire

// File: rtl/data_cache_array.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_cache_array : flop array, async read, per-lane write enables   (rev 1.0)
// -----------------------------------------------------------------------------
module data_cache_array
   import cache_types::*;
#(
   parameter int S_INDEX  = 3,
   parameter int WIDTH    = LINE_BITS,
   parameter int LANES    = LINE_BYTES,
   parameter int RESET_EN = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [S_INDEX-1:0] index,
   input  logic [LANES-1:0]   we,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   rdata
);

   localparam int DEPTH  = 2 ** S_INDEX;
   localparam int LANE_W = WIDTH / LANES;

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[index];

   generate
      if (RESET_EN != 0) begin : g_reset
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else begin
               for (int l = 0; l < LANES; l++)
                  if (we[l]) mem[index][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
            end
         end
      end else begin : g_noreset
         // Storage without reset; rst is intentionally not consumed here.
         logic unused_rst;
         assign unused_rst = rst;
         always_ff @(posedge clk) begin
            for (int l = 0; l < LANES; l++)
               if (we[l]) mem[index][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_cache : direct-mapped, write-back, write-allocate L1 data cache (rev 1.0)
// -----------------------------------------------------------------------------
module data_cache
   import cache_types::*;
#(
   parameter int S_INDEX = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         data_read,
   input  logic         data_write,
   input  logic [3:0]   data_mbe,
   input  logic [31:0]  data_addr,
   input  logic [31:0]  data_wdata,
   output logic         data_resp,
   output logic [31:0]  data_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam int TAG_W = 32 - OFFSET_W - S_INDEX;

   cache_state_t state, next_state;

   logic [S_INDEX-1:0] index;
   logic [TAG_W-1:0]   req_tag;
   logic [WORD_W-1:0]  word;
   logic               req;
   logic               hit;

   cache_line_t        line_rd, line_wd;
   logic [31:0]        line_be, store_be;
   logic [TAG_W-1:0]   tag_rd;
   logic               valid_rd, dirty_rd;
   logic               tag_we, valid_we, dirty_we, dirty_wd;

   assign index   = data_addr[OFFSET_W+S_INDEX-1:OFFSET_W];
   assign req_tag = data_addr[31:OFFSET_W+S_INDEX];
   assign word    = data_addr[4:2];
   assign req     = data_read | data_write;
   assign hit     = valid_rd && (tag_rd == req_tag);

   // Byte-lane offsets within the line: word select picks a group of 4 enables.
   assign store_be = 32'(data_mbe) << {word, 2'b00};

   logic unused_addr;
   assign unused_addr = ^data_addr[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state   = state;
      data_resp    = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      line_be      = '0;
      line_wd      = {8{data_wdata}};
      tag_we       = 1'b0;
      valid_we     = 1'b0;
      dirty_we     = 1'b0;
      dirty_wd     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req) begin
               if (hit) begin
                  data_resp = 1'b1;
                  if (data_write) begin
                     line_be  = store_be;
                     dirty_we = 1'b1;
                     dirty_wd = 1'b1;
                  end
               end else if (valid_rd && dirty_rd) begin
                  next_state = ST_WRITEBACK;
               end else begin
                  next_state = ST_FILL;
               end
            end
         end
         ST_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_rd, index, 5'b0};
            pmem_wdata   = line_rd;
            if (pmem_resp) begin
               dirty_we   = 1'b1;
               next_state = ST_FILL;
            end
         end
         ST_FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, index, 5'b0};
            line_wd      = pmem_rdata;
            if (pmem_resp) begin
               line_be    = '1;
               tag_we     = 1'b1;
               valid_we   = 1'b1;
               dirty_we   = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign data_rdata = line_rd[word*32 +: 32];

   data_cache_array #(.S_INDEX(S_INDEX), .WIDTH(LINE_BITS), .LANES(LINE_BYTES), .RESET_EN(0)) u_data (
      .clk(clk), .rst(rst), .index(index), .we(line_be), .wdata(line_wd), .rdata(line_rd)
   );

   data_cache_array #(.S_INDEX(S_INDEX), .WIDTH(TAG_W), .LANES(1), .RESET_EN(0)) u_tag (
      .clk(clk), .rst(rst), .index(index), .we(tag_we), .wdata(req_tag), .rdata(tag_rd)
   );

   data_cache_array #(.S_INDEX(S_INDEX), .WIDTH(1), .LANES(1), .RESET_EN(1)) u_valid (
      .clk(clk), .rst(rst), .index(index), .we(valid_we), .wdata(1'b1), .rdata(valid_rd)
   );

   data_cache_array #(.S_INDEX(S_INDEX), .WIDTH(1), .LANES(1), .RESET_EN(1)) u_dirty (
      .clk(clk), .rst(rst), .index(index), .we(dirty_we), .wdata(dirty_wd), .rdata(dirty_rd)
   );

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_data_cache : directed self-checking bench for data_cache          (rev 1.0)
// -----------------------------------------------------------------------------
module tb_data_cache;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         data_read, data_write;
   logic [3:0]   data_mbe;
   logic [31:0]  data_addr, data_wdata;
   logic         data_resp;
   logic [31:0]  data_rdata;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;

   int checks   = 0;
   int failures = 0;

   data_cache #(.S_INDEX(3)) dut (
      .clk(clk), .rst(rst),
      .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_resp(data_resp), .data_rdata(data_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line with word i = base+i, except word 'hot' which carries 'val'.
   function automatic logic [255:0] make_line(input logic [31:0] base, input int hot, input logic [31:0] val);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = (i == hot) ? val : base + 32'(i);
      return l;
   endfunction

   initial begin
      data_read  = 1'b0;
      data_write = 1'b0;
      data_mbe   = 4'h0;
      data_addr  = '0;
      data_wdata = '0;
      pmem_rdata = '0;
      pmem_resp  = 1'b0;

      @(negedge clk); #1;
      check("rst_resp",  data_resp,    1'b0);
      check("rst_read",  pmem_read,    1'b0);
      check("rst_write", pmem_write,   1'b0);
      check("rst_addr",  pmem_address, 32'h0);

      // 1. read miss from reset, fill, then hit
      @(negedge clk); rst = 1'b0; data_read = 1'b1; data_addr = 32'h0000_1004; #1;
      check("t1_miss_resp", data_resp, 1'b0);
      check("t1_idle_read", pmem_read, 1'b0);
      @(negedge clk); #1;
      check("t1_fill_read",  pmem_read,    1'b1);
      check("t1_fill_write", pmem_write,   1'b0);
      check("t1_fill_addr",  pmem_address, 32'h0000_1000);
      pmem_rdata = make_line(32'h1111_0000, 1, 32'hDEAD_BEEF);
      pmem_resp  = 1'b1;
      @(negedge clk); pmem_resp = 1'b0; #1;
      check("t1_resp",      data_resp,  1'b1);
      check("t1_rdata",     data_rdata, 32'hDEAD_BEEF);
      check("t1_read_drop", pmem_read,  1'b0);
      @(negedge clk); #1;
      check("t1_rehit_resp",  data_resp,  1'b1);
      check("t1_rehit_read",  pmem_read,  1'b0);
      check("t1_rehit_write", pmem_write, 1'b0);
      data_addr = 32'h0000_1008; #1;
      check("t1_word2", data_rdata, 32'h1111_0002);

      // 2. byte store hit and read back
      @(negedge clk);
      data_read = 1'b0; data_write = 1'b1; data_addr = 32'h0000_1004;
      data_mbe = 4'b0010; data_wdata = 32'h0000_AB00; #1;
      check("t2_wr_resp", data_resp, 1'b1);
      @(negedge clk); data_write = 1'b0; data_read = 1'b1; #1;
      check("t2_rd_resp",  data_resp,  1'b1);
      check("t2_rd_rdata", data_rdata, 32'hDEAD_ABEF);

      // 3. dirty conflict: writeback then fill
      @(negedge clk); data_addr = 32'h0000_1104; #1;
      check("t3_miss_resp", data_resp, 1'b0);
      @(negedge clk); #1;
      check("t3_wb_write", pmem_write,         1'b1);
      check("t3_wb_read",  pmem_read,          1'b0);
      check("t3_wb_addr",  pmem_address,       32'h0000_1000);
      check("t3_wb_word1", pmem_wdata[63:32],  32'hDEAD_ABEF);
      check("t3_wb_word0", pmem_wdata[31:0],   32'h1111_0000);
      repeat (3) @(negedge clk);
      #1;
      check("t3_wb_hold", pmem_write, 1'b1);
      check("t3_wb_nresp", data_resp, 1'b0);
      pmem_resp = 1'b1;
      @(negedge clk); pmem_resp = 1'b0; #1;
      check("t3_fill_read",  pmem_read,    1'b1);
      check("t3_fill_write", pmem_write,   1'b0);
      check("t3_fill_addr",  pmem_address, 32'h0000_1100);
      pmem_rdata = make_line(32'h2222_0000, 1, 32'hCAFE_F00D);
      pmem_resp  = 1'b1;
      @(negedge clk); pmem_resp = 1'b0; #1;
      check("t3_resp",  data_resp,  1'b1);
      check("t3_rdata", data_rdata, 32'hCAFE_F00D);

      // no request, stray pmem_resp ignored
      @(negedge clk); data_read = 1'b0; pmem_resp = 1'b1; #1;
      check("idle_resp",  data_resp,    1'b0);
      check("idle_read",  pmem_read,    1'b0);
      check("idle_write", pmem_write,   1'b0);
      check("idle_addr",  pmem_address, 32'h0);
      check("idle_wdata", pmem_wdata,   256'h0);
      @(negedge clk); pmem_resp = 1'b0; #1;
      check("idle_stray_read",  pmem_read,  1'b0);
      check("idle_stray_write", pmem_write, 1'b0);

      // 4. write miss to a clean line: fill only, then store merges as a hit
      data_write = 1'b1; data_addr = 32'h0000_2008; data_mbe = 4'b1111; data_wdata = 32'h1234_5678; #1;
      check("t4_miss_resp", data_resp, 1'b0);
      @(negedge clk); #1;
      check("t4_fill_read",  pmem_read,    1'b1);
      check("t4_fill_write", pmem_write,   1'b0);
      check("t4_fill_addr",  pmem_address, 32'h0000_2000);
      pmem_rdata = make_line(32'h3333_0000, 8, 32'h0);
      pmem_resp  = 1'b1;
      @(negedge clk); pmem_resp = 1'b0; #1;
      check("t4_wr_resp", data_resp, 1'b1);
      @(negedge clk); data_write = 1'b0; data_read = 1'b1; #1;
      check("t4_rdata", data_rdata, 32'h1234_5678);
      data_addr = 32'h0000_200C; #1;
      check("t4_word3", data_rdata, 32'h3333_0003);
      data_addr = 32'h0000_1008; #1;
      check("t4_conflict_resp", data_resp, 1'b0);
      @(negedge clk); #1;
      check("t4_wb_write", pmem_write,        1'b1);
      check("t4_wb_addr",  pmem_address,      32'h0000_2000);
      check("t4_wb_word2", pmem_wdata[95:64], 32'h1234_5678);
      pmem_resp = 1'b1;
      @(negedge clk); pmem_resp = 1'b0; #1;
      check("t4_fill_read2", pmem_read,    1'b1);
      check("t4_fill_addr2", pmem_address, 32'h0000_1000);

      // 5. slow memory: FILL holds steady for 20 cycles
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         check("t5_resp", data_resp,    1'b0);
         check("t5_read", pmem_read,    1'b1);
         check("t5_addr", pmem_address, 32'h0000_1000);
      end

      // 6. asynchronous reset mid-fill
      @(negedge clk); #2; rst = 1'b1; #1;
      check("t6_async_read", pmem_read,    1'b0);
      check("t6_async_addr", pmem_address, 32'h0);
      @(negedge clk); rst = 1'b0; data_addr = 32'h0000_1004; #1;
      check("t6_miss_resp", data_resp, 1'b0);
      @(negedge clk); #1;
      check("t6_fill_read", pmem_read,    1'b1);
      check("t6_fill_addr", pmem_address, 32'h0000_1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
